adc_delay_aligner: RTL and testbench
====================================

Name: adc_delay_aligner

Overview:
- Sits between an ADC driver and the experiment control FSM; one instance on the MAC path and one on the NL path.
- Delays the raw ADC sample stream by a programmable number of samples, held in a circular buffer, so returning pulses line up with the DAC instruction stream.
- The delay value comes from the delay-measurement results.
- Removes a static offset with signed saturation and presents the sample/valid pair the FSM consumes as mac_val_in/mac_val_valid (or nl_val_in/nl_val_valid).

Parameters:
- NUM_BITS, 16, sample width; two's complement; matches num_bits in ising_config.
- ADDR_W, 8, buffer address width; depth is 2^ADDR_W.
- MAX_DEL, 255, largest accepted delay in samples; must be ≤ 2^ADDR_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- adc_tdata  in  NUM_BITS  raw signed ADC sample.
- adc_tvalid  in  1  sample strobe; no backpressure, so every valid sample is taken.
- run  in  1  enable from the FSM (mac_run/nl_run); level-sensitive.
- del_cfg  in  16  requested delay in samples; latched on the run rising edge.
- offset  in  NUM_BITS  signed offset subtracted from each output sample; sampled live.
- val_out  out  NUM_BITS  aligned, offset-corrected sample.
- val_valid  out  1  one-cycle strobe per val_out.
- sat_err  out  1  sticky; set when any output saturated.
- cfg_err  out  1  sticky; set when del_cfg > MAX_DEL at latch.
- state_out  out  2  current state, for debug readback.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE.
  - val_out=0, val_valid=0, sat_err=0, cfg_err=0.
  - Write pointer, fill counter and latched delay all 0.
  - Buffer contents need not be cleared.
- States (state_out encoding): IDLE=0, FILL=1, STREAM=2.
- IDLE:
  - val_valid=0; adc samples are ignored.
  - On run high (first cycle seen), go to FILL, or directly to STREAM if the effective delay is 0.
  - In that same cycle:
    - latch del_eff = min(del_cfg, MAX_DEL);
    - set cfg_err=1 if del_cfg > MAX_DEL, else clear cfg_err;
    - clear sat_err, write pointer and fill counter.
- FILL:
  - Each adc_tvalid writes the sample at wr_ptr, increments wr_ptr (modulo 2^ADDR_W) and increments fill_cnt.
  - val_valid=0.
  - When the write makes fill_cnt reach del_eff, go to STREAM next cycle.
- STREAM:
  - Each adc_tvalid writes the new sample and reads the sample written del_eff valid-samples earlier: address (wr_ptr - del_eff) mod 2^ADDR_W.
  - With del_eff=0 the new sample itself is used (bypass path, no buffer read-before-write hazard).
  - Output is registered: val_out/val_valid appear exactly 1 cycle after the triggering adc_tvalid.
  - A cycle with no adc_tvalid gives val_valid=0 and no pointer movement; val_out holds its last value.
- Arithmetic:
  - diff = sext(sample) - sext(offset), computed at NUM_BITS+1 bits.
  - Clamp to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1]; set sat_err on any clamp.
- Run low in any state:
  - Return to IDLE next cycle.
  - val_valid=0 from that cycle on.
  - An output already registered for this cycle is still presented.
- Latched values:
  - del_cfg changes while run is high are ignored.
  - sat_err and cfg_err hold until the next run rising edge or reset.
- Reset mid-operation: immediate return to reset values; a partially filled buffer is discarded.
- Wrap-around: pointers wrap silently at 2^ADDR_W; del_eff ≤ MAX_DEL guarantees no overwrite of unread data.

Optional Feature:
- Macro: ADC_DELAY_ALIGNER_PEAK_EN.
- Defined:
  - Adds output peak_mag (NUM_BITS, unsigned) holding the maximum |val_out| over all valid outputs since the run rising edge.
  - Updated in the cycle after val_valid; cleared on run rising edge and reset.
  - |−2^(NUM_BITS-1)| saturates to 2^(NUM_BITS-1)-1.
- Undefined: port absent; no extra logic.

Test Plan:
- del_cfg=4, offset=0, run=1, ramp adc_tdata 1,2,3… with tvalid every cycle -> first val_valid on cycle 6 after run rise, val_out sequence 1,2,3…; state_out 0→1→2.
- del_cfg=0, offset=5, samples 10,−3 -> val_out 5,−8, each 1 cycle after the input; FILL never entered.
- offset=−100, sample 32760 -> val_out=32767, sat_err=1; then sample 0 -> val_out=100, sat_err stays 1 until the next run rise.
- del_cfg=300 -> cfg_err=1, delay 255 applied (first output after 255 fill samples + 1 cycle); tvalid gaps of 3 cycles -> no output during gaps, order preserved.
- run drop mid-STREAM, then rst pulse mid-FILL -> val_valid=0 from the cycle after run drop; all outputs at reset values during rst low; a new run rise refills from zero.
- With ADC_DELAY_ALIGNER_PEAK_EN, del_cfg=0, outputs −7,3,−32768 -> peak_mag 7, 7, 32767.

Source files
------------

// File: rtl/adc_delay_aligner.sv
// ADC sample delay aligner: circular-buffer delay, offset removal with signed saturation.
// Optional peak magnitude tracker enabled by defining ADC_DELAY_ALIGNER_PEAK_EN.
module adc_delay_aligner #(
    parameter int NUM_BITS = 16,
    parameter int ADDR_W   = 8,
    parameter int MAX_DEL  = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_BITS-1:0] adc_tdata_i,
    input  logic                adc_tvalid_i,
    input  logic                run_i,
    input  logic [15:0]         del_cfg_i,
    input  logic [NUM_BITS-1:0] offset_i,
    output logic [NUM_BITS-1:0] val_out_o,
    output logic                val_valid_o,
    output logic                sat_err_o,
    output logic                cfg_err_o,
`ifdef ADC_DELAY_ALIGNER_PEAK_EN
    output logic [NUM_BITS-1:0] peak_mag_o,
`endif
    output logic [1:0]          state_out_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam logic signed [NUM_BITS:0] SMAX = {2'b00, {(NUM_BITS-1){1'b1}}};
    localparam logic signed [NUM_BITS:0] SMIN = {2'b11, {(NUM_BITS-1){1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   del_q, del_d;
    logic [NUM_BITS-1:0] val_q, val_d;
    logic                vld_q, vld_d;
    logic                sat_q, sat_d;
    logic                cfg_q, cfg_d;
    logic                wr_en;

    logic [NUM_BITS-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0]   rd_addr;
    logic [NUM_BITS-1:0] src;
    logic signed [NUM_BITS:0] diff;
    logic [NUM_BITS-1:0] clamped;
    logic                clamp_hit;
    logic                cfg_over;
    logic [ADDR_W-1:0]   del_req;

    assign cfg_over = int'(del_cfg_i) > MAX_DEL;
    assign del_req  = cfg_over ? ADDR_W'(MAX_DEL) : ADDR_W'(del_cfg_i);

    // Zero delay bypasses the buffer so the read never races the write.
    assign rd_addr = wr_ptr_q - del_q;
    assign src     = (del_q == '0) ? adc_tdata_i : mem[rd_addr];
    assign diff    = $signed({src[NUM_BITS-1], src}) - $signed({offset_i[NUM_BITS-1], offset_i});

    always_comb begin
        clamped   = diff[NUM_BITS-1:0];
        clamp_hit = 1'b0;
        if (diff > SMAX) begin
            clamped   = SMAX[NUM_BITS-1:0];
            clamp_hit = 1'b1;
        end else if (diff < SMIN) begin
            clamped   = SMIN[NUM_BITS-1:0];
            clamp_hit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        del_d    = del_q;
        val_d    = val_q;
        vld_d    = 1'b0;
        sat_d    = sat_q;
        cfg_d    = cfg_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_i) begin
                    del_d    = del_req;
                    cfg_d    = cfg_over;
                    sat_d    = 1'b0;
                    wr_ptr_d = '0;
                    fill_d   = '0;
                    state_d  = (del_req == '0) ? STREAM : FILL;
                end
            end
            FILL: begin
                if (!run_i) begin
                    state_d = IDLE;
                end else if (adc_tvalid_i) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    fill_d   = fill_q + 1'b1;
                    if (fill_q + 1'b1 == del_q) state_d = STREAM;
                end
            end
            STREAM: begin
                if (!run_i) begin
                    state_d = IDLE;
                end else if (adc_tvalid_i) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    vld_d    = 1'b1;
                    val_d    = clamped;
                    if (clamp_hit) sat_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            del_q    <= '0;
            val_q    <= '0;
            vld_q    <= 1'b0;
            sat_q    <= 1'b0;
            cfg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            del_q    <= del_d;
            val_q    <= val_d;
            vld_q    <= vld_d;
            sat_q    <= sat_d;
            cfg_q    <= cfg_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= adc_tdata_i;
    end

    assign val_out_o   = val_q;
    assign val_valid_o = vld_q;
    assign sat_err_o   = sat_q;
    assign cfg_err_o   = cfg_q;
    assign state_out_o = state_q;

`ifdef ADC_DELAY_ALIGNER_PEAK_EN
    logic [NUM_BITS-1:0] peak_q, peak_d;
    logic [NUM_BITS-1:0] mag;

    // Most negative value has no positive twin; it saturates to the positive maximum.
    always_comb begin
        mag = val_q;
        if (val_q[NUM_BITS-1]) begin
            mag = (val_q == SMIN[NUM_BITS-1:0]) ? SMAX[NUM_BITS-1:0] : (~val_q + 1'b1);
        end
        peak_d = peak_q;
        if (state_q == IDLE && run_i) peak_d = '0;
        else if (vld_q && mag > peak_q) peak_d = mag;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) peak_q <= '0;
        else         peak_q <= peak_d;
    end

    assign peak_mag_o = peak_q;
`endif

endmodule

// File: tb/tb_adc_delay_aligner.sv
// Bench for adc_delay_aligner: directed plan steps plus randomized runs against a queue model.
module tb_adc_delay_aligner;
    localparam int NB = 16;
    localparam int MD = 255;
    localparam int HI = (1 << (NB-1)) - 1;
    localparam int LO = -(1 << (NB-1));

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NB-1:0] adc_tdata_i = '0;
    logic          adc_tvalid_i = 1'b0;
    logic          run_i = 1'b0;
    logic [15:0]   del_cfg_i = '0;
    logic [NB-1:0] offset_i = '0;
    logic [NB-1:0] val_out_o;
    logic          val_valid_o, sat_err_o, cfg_err_o;
    logic [1:0]    state_out_o;
`ifdef ADC_DELAY_ALIGNER_PEAK_EN
    logic [NB-1:0] peak_mag_o;
`endif

    adc_delay_aligner dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .adc_tdata_i(adc_tdata_i), .adc_tvalid_i(adc_tvalid_i),
        .run_i(run_i), .del_cfg_i(del_cfg_i), .offset_i(offset_i), .val_out_o(val_out_o),
        .val_valid_o(val_valid_o), .sat_err_o(sat_err_o), .cfg_err_o(cfg_err_o),
`ifdef ADC_DELAY_ALIGNER_PEAK_EN
        .peak_mag_o(peak_mag_o),
`endif
        .state_out_o(state_out_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: accepted samples since the run rise; an output pops once more than del are held.
    int            hist[$];
    bit            m_run;
    int            m_del, m_cnt, m_peak;
    logic          m_vld, m_sat, m_cfg;
    logic [NB-1:0] m_out;
    int            vcount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_run = 0; m_del = 0; m_cnt = 0; m_peak = 0;
        m_vld = 0; m_sat = 0; m_cfg = 0; m_out = '0;
    endtask

    task automatic check_all(input string tag);
        logic [1:0] es;
        es = !m_run ? 2'd0 : (m_cnt >= m_del ? 2'd2 : 2'd1);
        chk({tag, ".valid"}, 32'(val_valid_o), 32'(m_vld));
        chk({tag, ".val_out"}, 32'(val_out_o), 32'(m_out));
        chk({tag, ".sat_err"}, 32'(sat_err_o), 32'(m_sat));
        chk({tag, ".cfg_err"}, 32'(cfg_err_o), 32'(m_cfg));
        chk({tag, ".state"}, 32'(state_out_o), 32'(es));
`ifdef ADC_DELAY_ALIGNER_PEAK_EN
        chk({tag, ".peak"}, 32'(peak_mag_o), 32'(m_peak));
`endif
    endtask

    task automatic step(input string tag, input bit run, input bit tv, input int data, input int off);
        int d, a;
        run_i = run; adc_tvalid_i = tv; adc_tdata_i = data[NB-1:0]; offset_i = off[NB-1:0];
        if (m_vld) begin
            a = $signed(m_out);
            a = (a < 0) ? -a : a;
            if (a > HI) a = HI;
            if (a > m_peak) m_peak = a;
        end
        m_vld = 0;
        if (!m_run) begin
            if (run) begin
                m_run = 1; m_cnt = 0; hist.delete();
                m_cfg = int'(del_cfg_i) > MD;
                m_del = m_cfg ? MD : int'(del_cfg_i);
                m_sat = 0; m_peak = 0;
            end
        end else if (!run) begin
            m_run = 0;
        end else if (tv) begin
            hist.push_back($signed(data[NB-1:0]));
            m_cnt++;
            if (hist.size() > m_del) begin
                d = hist.pop_front() - int'($signed(off[NB-1:0]));
                if (d > HI) begin d = HI; m_sat = 1; end
                if (d < LO) begin d = LO; m_sat = 1; end
                m_vld = 1; m_out = d[NB-1:0];
            end
        end
        @(posedge clk_i); #1;
        if (val_valid_o === 1'b1) vcount++;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_ni = 1'b0; run_i = 1'b0; adc_tvalid_i = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk_i); #1;
        check_all(tag);
        rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        vcount = 0;
        #1;
        check_all("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        step("idle", 0, 1, 77, 0);

        // Delay 4 ramp
        del_cfg_i = 16'd4;
        step("ramp_rise", 1, 0, 0, 0);
        for (int i = 1; i <= 12; i++) step("ramp", 1, 1, i, 0);
        chk("ramp_last", 32'(val_out_o), 32'd8);

        // Zero delay bypass with offset
        step("stop1", 0, 0, 0, 0);
        del_cfg_i = 16'd0;
        step("bypass_rise", 1, 0, 0, 5);
        step("bypass_a", 1, 1, 10, 5);
        chk("bypass_5", 32'(val_out_o), 32'(16'd5));
        step("bypass_b", 1, 1, -3, 5);
        chk("bypass_m8", 32'(val_out_o), 32'(16'hFFF8));

        // Positive saturation, sticky sat_err
        step("sat_a", 1, 1, 32760, -100);
        chk("sat_max", 32'(val_out_o), 32'(16'h7FFF));
        chk("sat_flag", 32'(sat_err_o), 32'd1);
        step("sat_gap", 1, 0, 0, -100);
        step("sat_b", 1, 1, 0, -100);
        chk("sat_100", 32'(val_out_o), 32'd100);
        chk("sat_sticky", 32'(sat_err_o), 32'd1);

        // Oversized delay clamps to MAX_DEL, sparse tvalid
        step("stop2", 0, 0, 0, 0);
        del_cfg_i = 16'd300;
        step("big_rise", 1, 0, 0, 0);
        del_cfg_i = 16'd3;
        vcount = 0;
        for (int i = 0; i < 262; i++) begin
            step("big_v", 1, 1, int'($urandom_range(0, 65535)) - 32768, 12);
            for (int g = 0; g < 3; g++) step("big_gap", 1, 0, 0, 12);
        end
        chk("big_count", 32'(vcount), 32'd7);
        chk("big_cfg", 32'(cfg_err_o), 32'd1);

        // Run drop mid-stream, then reset mid-fill and refill
        step("drop", 0, 1, 99, 0);
        chk("drop_vld", 32'(val_valid_o), 32'd0);
        del_cfg_i = 16'd10;
        step("rf_rise", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("rf_fill", 1, 1, 1000 + i, 0);
        do_reset("mid_rst");
        step("rf_rise2", 1, 1, 7, 0);
        for (int i = 0; i < 15; i++) step("refill", 1, 1, 2000 + i, 3);
        chk("refill_last", 32'(val_out_o), 32'd2001);

        // Peak magnitude sequence
        step("stop3", 0, 0, 0, 0);
        del_cfg_i = 16'd0;
        step("pk_rise", 1, 0, 0, 0);
        step("pk_a", 1, 1, -7, 0);
        step("pk_b", 1, 1, 3, 0);
        step("pk_c", 1, 1, -32768, 0);
        step("pk_d", 1, 0, 0, 0);
`ifdef ADC_DELAY_ALIGNER_PEAK_EN
        chk("pk_final", 32'(peak_mag_o), 32'd32767);
`endif

        // Randomized runs: random delay, gaps, offsets, run drops, del_cfg churn
        for (int r = 0; r < 8; r++) begin
            step("rnd_stop", 0, 0, 0, 0);
            del_cfg_i = 16'($urandom_range(0, 20));
            for (int c = 0; c < 80; c++) begin
                int off;
                off = ($urandom % 4 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                          : int'($urandom_range(0, 200)) - 100;
                step("rnd", ($urandom % 40) != 0, ($urandom % 4) != 0,
                     int'($urandom_range(0, 65535)) - 32768, off);
                if ($urandom % 10 == 0) del_cfg_i = 16'($urandom_range(0, 20));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
